mem_access_unit: RTL

Parametrised MEM pipeline stage with a data-memory handshake and an integrated MEM/WB register. Detects out-of-range and misaligned accesses, and supports byte/half/word/dword loads and stores with byte enables and sign/zero extension. Stalls upstream while a memory transaction is outstanding. Sits between the EX/MEM register and write-back and drives a request/acknowledge data-memory port.

---
 rtl/mem_access_unit_pkg.sv | 37 +++
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit_load_align.sv | 35 +++
 rtl/mem_access_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM stage: access sizes, FSM states,
// the latched request control word and lane arithmetic.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Control captured with an accepted memory op, consumed at completion.
    typedef struct packed {
        logic  memtoreg;
        logic  regwrite;
        logic  is_unsigned;
        logic  we;
        size_e size;
    } req_ctrl_t;

    function automatic int unsigned lane_count(input int unsigned xlen);
        return xlen / 8;
    endfunction

    // Bytes touched by an access, clamped to the bus width (D on a 32-bit bus).
    function automatic int unsigned size_bytes(input size_e sz, input int unsigned lanes);
        int unsigned n;
        n = 32'd1 << sz;
        return (n > lanes) ? lanes : n;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory port between the MEM stage and memory.
interface mem_access_unit_if
    import mem_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned MEM_WORDS = 1024
);
    localparam int unsigned LANES = lane_count(XLEN);
    localparam int unsigned AW    = $clog2(MEM_WORDS);

    logic             dmem_req;
    logic             dmem_we;
    logic [AW-1:0]    dmem_addr;
    logic [LANES-1:0] dmem_be;
    logic [XLEN-1:0]  dmem_wdata;
    logic             dmem_ack;
    logic [XLEN-1:0]  dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: picks the addressed lanes out of the read word and
// sign- or zero-extends them to XLEN.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    localparam int unsigned LANES = lane_count(XLEN),
    localparam int unsigned OFF_W = $clog2(LANES)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [OFF_W-1:0] offset,
    input  size_e            size,
    input  logic             is_unsigned,
    output logic [XLEN-1:0]  data_c
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;
    int unsigned     nb;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        nb      = size_bytes(size, LANES);
        mask    = '0;
        sign    = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i < nb) mask[i*8 +: 8] = 8'hFF;
            if (i == nb - 1) sign = shifted[i*8 + 7];
        end
        if (is_unsigned) sign = 1'b0;
        data_c = (shifted & mask) | ({XLEN{sign}} & ~mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage with data-memory handshake and MEM/WB register.
// MEM_FAULT_CHECK_EN enables range/alignment faulting; otherwise addresses wrap.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned REG_AW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [63:0]       addr_in,
    input  logic [XLEN-1:0]   wdata_in,
    input  logic [1:0]        size_in,
    input  logic              unsigned_in,
    input  logic              memread_in,
    input  logic              memwrite_in,
    input  logic              memtoreg_in,
    input  logic              regwrite_in,
    input  logic [REG_AW-1:0] write_reg_in,
    output logic              stall_o,
    mem_access_unit_if.master dmem_if,
    output logic              wb_valid,
    output logic [XLEN-1:0]   alu_result_out,
    output logic [XLEN-1:0]   read_data_out,
    output logic [REG_AW-1:0] write_reg_out,
    output logic              memtoreg_out,
    output logic              regwrite_out,
    output logic              inv_mem_addr
);

    localparam int unsigned LANES = lane_count(XLEN);
    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned BE_W2 = 2 * LANES;

    state_e            state_q, state_nxt;
    logic              drop_q, drop_nxt;
    logic              accept_c, wb_pass_c, wb_fault_c, wb_mem_c;
    logic              fault_c;

    size_e             size_c;
    logic [63:0]       word_idx;
    logic [OFF_W-1:0]  off_c;
    int unsigned       nb_c;
    logic [BE_W2-1:0]  be_wide;
    logic [LANES-1:0]  be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   load_c;

    logic              req_q;
    logic [AW-1:0]     waddr_q;
    logic [LANES-1:0]  be_q;
    logic [XLEN-1:0]   wdata_q;
    logic [OFF_W-1:0]  off_q;
    req_ctrl_t         ctrl_q;
    logic [XLEN-1:0]   alu_q;
    logic [REG_AW-1:0] wreg_q;
    logic              unused_bits;

    assign size_c   = size_e'(size_in);
    assign word_idx = addr_in >> OFF_W;
    assign off_c    = addr_in[OFF_W-1:0];

    // Byte enables and lane-replicated store data for the incoming op
    always_comb begin
        nb_c    = size_bytes(size_c, LANES);
        be_wide = ((BE_W2'(1) << nb_c) - BE_W2'(1)) << off_c;
        be_c    = be_wide[LANES-1:0];
        wdata_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            wdata_c[i*8 +: 8] = wdata_in[(i & (nb_c - 1)) * 8 +: 8];
        end
    end

`ifdef MEM_FAULT_CHECK_EN
    logic misalign_c;
    logic range_c;

    always_comb begin
        misalign_c = 1'b0;
        case (size_c)
            SZ_B:    misalign_c = 1'b0;
            SZ_H:    misalign_c = addr_in[0];
            SZ_W:    misalign_c = |addr_in[1:0];
            SZ_D:    misalign_c = (XLEN == 32) || (|addr_in[2:0]);
            default: misalign_c = 1'b1;
        endcase
    end

    assign range_c = word_idx > 64'(MEM_WORDS - 1);
    assign fault_c = misalign_c | range_c;
`else
    assign fault_c = 1'b0;
`endif

    assign unused_bits = ^{word_idx, be_wide};

    // FSM state and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            drop_q  <= drop_nxt;
        end
    end

    // Next state, stall and MEM/WB load selection
    always_comb begin
        state_nxt  = state_q;
        drop_nxt   = drop_q;
        accept_c   = 1'b0;
        wb_pass_c  = 1'b0;
        wb_fault_c = 1'b0;
        wb_mem_c   = 1'b0;
        stall_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in && !flush) begin
                    if (memread_in || memwrite_in) begin
                        if (fault_c) begin
                            wb_fault_c = 1'b1;
                        end else begin
                            accept_c  = 1'b1;
                            stall_o   = 1'b1;
                            state_nxt = ST_REQ;
                        end
                    end else begin
                        wb_pass_c = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_if.dmem_ack) begin
                    state_nxt = ST_IDLE;
                    drop_nxt  = 1'b0;
                    wb_mem_c  = !(drop_q || flush);
                end else begin
                    stall_o = 1'b1;
                    if (flush) drop_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request registers: captured on accept, held stable until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            off_q   <= '0;
            ctrl_q  <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
        end else begin
            req_q <= (state_nxt == ST_REQ);
            if (accept_c) begin
                waddr_q            <= word_idx[AW-1:0];
                be_q               <= be_c;
                wdata_q            <= wdata_c;
                off_q              <= off_c;
                ctrl_q.memtoreg    <= memtoreg_in;
                ctrl_q.regwrite    <= regwrite_in;
                ctrl_q.is_unsigned <= unsigned_in;
                ctrl_q.we          <= memwrite_in;
                ctrl_q.size        <= size_c;
                alu_q              <= addr_in[XLEN-1:0];
                wreg_q             <= write_reg_in;
            end
        end
    end

    assign dmem_if.dmem_req   = req_q;
    assign dmem_if.dmem_we    = ctrl_q.we;
    assign dmem_if.dmem_addr  = waddr_q;
    assign dmem_if.dmem_be    = be_q;
    assign dmem_if.dmem_wdata = wdata_q;

    mem_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (dmem_if.dmem_rdata),
        .offset      (off_q),
        .size        (ctrl_q.size),
        .is_unsigned (ctrl_q.is_unsigned),
        .data_c      (load_c)
    );

    // MEM/WB register; anything not selected below is a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid       <= 1'b0;
            alu_result_out <= '0;
            read_data_out  <= '0;
            write_reg_out  <= '0;
            memtoreg_out   <= 1'b0;
            regwrite_out   <= 1'b0;
            inv_mem_addr   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            regwrite_out <= 1'b0;
            inv_mem_addr <= 1'b0;
            if (wb_pass_c || wb_fault_c) begin
                wb_valid       <= 1'b1;
                alu_result_out <= addr_in[XLEN-1:0];
                read_data_out  <= '0;
                write_reg_out  <= write_reg_in;
                memtoreg_out   <= memtoreg_in;
                regwrite_out   <= wb_pass_c & regwrite_in;
                inv_mem_addr   <= wb_fault_c;
            end else if (wb_mem_c) begin
                wb_valid       <= 1'b1;
                alu_result_out <= alu_q;
                read_data_out  <= ctrl_q.we ? '0 : load_c;
                write_reg_out  <= wreg_q;
                memtoreg_out   <= ctrl_q.memtoreg;
                regwrite_out   <= ctrl_q.regwrite;
            end
        end
    end

endmodule
